// File: rtl/core_pkg.sv
// Shared core definitions: register-file geometry, writeback source ids and
// the {rd,data} entry carried through the writeback buffers.
package core_pkg;

  localparam int XLEN          = 64;
  localparam int REG_ADDR_W    = 5;
  localparam int NUM_REGS      = 1 << REG_ADDR_W;
  localparam int WB_FIFO_DEPTH = 2;

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_LSU = 1'b1
  } wb_src_e;

  // rd sits in the MSBs so a raw entry vector can be sliced for its address.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

  // x0 is never reported as pending.
  function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd,
                                                    input logic                  en);
    logic [NUM_REGS-1:0] oh;
    oh = '0;
    if (en && (rd != '0)) oh[rd] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small in-order FIFO for one writeback source; exposes every slot with a
// valid flag so the owner can see all buffered destinations at once.
module wb_fifo import core_pkg::*; #(
  parameter int DATA_W = 69,
  parameter int DEPTH  = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  logic [DATA_W-1:0]            data_i,
  input  logic                         pop_i,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [DATA_W-1:0]            head_o,
  output logic [CNT_W-1:0]             count_o,
  output logic [DEPTH-1:0][DATA_W-1:0] ent_o,
  output logic [DEPTH-1:0]             ent_vld_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Acceptance depends only on the registered count, never on a same-cycle pop.
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    rd_ptr_d = do_pop  ? next_ptr(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = do_push ? next_ptr(wr_ptr_q) : wr_ptr_q;
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_o[i]     = mem_q[i];
      ent_vld_o[i] = (((i + DEPTH - int'(rd_ptr_q)) % DEPTH) < int'(count_q));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Merges ALU and load-unit results onto the single register-file write port,
// buffering each source and tracking which registers have writes in flight.
module writeback_arbiter import core_pkg::*; (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [REG_ADDR_W-1:0] lsu_rd,
  input  logic [XLEN-1:0]       lsu_data,
  output logic                  wen,
  output logic [REG_ADDR_W-1:0] waddr,
  output logic [XLEN-1:0]       wdata,
  output logic [NUM_REGS-1:0]   pend_vec
);

  localparam int ENT_W = $bits(wb_entry_t);
  localparam int CNT_W = $clog2(WB_FIFO_DEPTH + 1);

  logic                                alu_full, alu_empty, lsu_full, lsu_empty;
  logic [ENT_W-1:0]                    alu_head, lsu_head;
  logic [CNT_W-1:0]                    alu_cnt, lsu_cnt;
  logic [WB_FIFO_DEPTH-1:0][ENT_W-1:0] alu_ent, lsu_ent;
  logic [WB_FIFO_DEPTH-1:0]            alu_ent_vld, lsu_ent_vld;
  logic                                grant_alu, grant_lsu;
  wb_entry_t                           win;
  logic                                unused_cnt;

  logic                  wen_q, wen_d;
  logic [REG_ADDR_W-1:0] waddr_q, waddr_d;
  logic [XLEN-1:0]       wdata_q, wdata_d;
  wb_src_e               last_grant_q, last_grant_d;

  assign alu_ready  = !rst && !alu_full;
  assign lsu_ready  = !rst && !lsu_full;
  assign unused_cnt = ^{alu_cnt, lsu_cnt};

  wb_fifo #(.DATA_W(ENT_W), .DEPTH(WB_FIFO_DEPTH)) u_alu_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (alu_valid && alu_ready),
    .data_i    ({alu_rd, alu_data}),
    .pop_i     (grant_alu),
    .full_o    (alu_full),
    .empty_o   (alu_empty),
    .head_o    (alu_head),
    .count_o   (alu_cnt),
    .ent_o     (alu_ent),
    .ent_vld_o (alu_ent_vld)
  );

  wb_fifo #(.DATA_W(ENT_W), .DEPTH(WB_FIFO_DEPTH)) u_lsu_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (lsu_valid && lsu_ready),
    .data_i    ({lsu_rd, lsu_data}),
    .pop_i     (grant_lsu),
    .full_o    (lsu_full),
    .empty_o   (lsu_empty),
    .head_o    (lsu_head),
    .count_o   (lsu_cnt),
    .ent_o     (lsu_ent),
    .ent_vld_o (lsu_ent_vld)
  );

  // Round-robin only matters on a tie; a lone non-empty head always wins.
  assign grant_alu = !alu_empty && (lsu_empty || (last_grant_q == WB_LSU));
  assign grant_lsu = !lsu_empty && !grant_alu;
  assign win       = grant_alu ? wb_entry_t'(alu_head) : wb_entry_t'(lsu_head);

  always_comb begin
    wen_d        = 1'b0;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    last_grant_d = last_grant_q;
    if (grant_alu || grant_lsu) begin
      last_grant_d = grant_alu ? WB_ALU : WB_LSU;
      if (win.rd != '0) begin
        wen_d   = 1'b1;
        waddr_d = win.rd;
        wdata_d = win.data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wen_q        <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      last_grant_q <= WB_LSU;
    end else begin
      wen_q        <= wen_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign wen   = wen_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;

  always_comb begin
    pend_vec = rd_onehot(waddr_q, wen_q);
    for (int i = 0; i < WB_FIFO_DEPTH; i++) begin
      pend_vec = pend_vec | rd_onehot(alu_ent[i][ENT_W-1 -: REG_ADDR_W], alu_ent_vld[i]);
      pend_vec = pend_vec | rd_onehot(lsu_ent[i][ENT_W-1 -: REG_ADDR_W], lsu_ent_vld[i]);
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Scoreboard bench: a queue-level model predicts every register write,
// readiness and pend_vec; a negedge monitor compares against the DUT.
module tb_writeback_arbiter;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, alu_ready, lsu_valid, lsu_ready;
  logic [4:0]  alu_rd, lsu_rd, waddr;
  logic [63:0] alu_data, lsu_data, wdata;
  logic        wen;
  logic [31:0] pend_vec;

  always #5 clk = ~clk;

  writeback_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .lsu_valid (lsu_valid),
    .lsu_ready (lsu_ready),
    .lsu_rd    (lsu_rd),
    .lsu_data  (lsu_data),
    .wen       (wen),
    .waddr     (waddr),
    .wdata     (wdata),
    .pend_vec  (pend_vec)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
  } ent_t;

  ent_t       mq_alu[$], mq_lsu[$], exp_q[$];
  bit         m_last_lsu, m_wen, m_alu_acc, m_lsu_acc, mon_en;
  logic [4:0] m_waddr;
  int         n_tests = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: each source is a bounded queue of two; one pop per cycle,
  // sole non-empty wins, ties go to whoever did not win last.
  always @(posedge clk) begin
    ent_t e;
    bit   ga, gl, ar, lr;
    if (rst) begin
      mq_alu.delete();
      mq_lsu.delete();
      exp_q.delete();
      m_last_lsu = 1'b1;
      m_wen      = 1'b0;
      m_waddr    = '0;
      m_alu_acc  = 1'b0;
      m_lsu_acc  = 1'b0;
      mon_en     = 1'b1;
    end else begin
      ar    = mq_alu.size() < 2;
      lr    = mq_lsu.size() < 2;
      ga    = (mq_alu.size() > 0) && ((mq_lsu.size() == 0) || m_last_lsu);
      gl    = (mq_lsu.size() > 0) && !ga;
      m_wen = 1'b0;
      if (ga || gl) begin
        e          = ga ? mq_alu.pop_front() : mq_lsu.pop_front();
        m_last_lsu = gl;
        if (e.rd != 0) begin
          m_wen   = 1'b1;
          m_waddr = e.rd;
          exp_q.push_back(e);
        end
      end
      m_alu_acc = alu_valid && ar;
      m_lsu_acc = lsu_valid && lr;
      if (m_alu_acc) mq_alu.push_back('{alu_rd, alu_data});
      if (m_lsu_acc) mq_lsu.push_back('{lsu_rd, lsu_data});
    end
  end

  function automatic logic [31:0] m_pend();
    logic [31:0] p;
    p = '0;
    foreach (mq_alu[i]) p[mq_alu[i].rd] = 1'b1;
    foreach (mq_lsu[i]) p[mq_lsu[i].rd] = 1'b1;
    if (m_wen) p[m_waddr] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  always @(negedge clk) begin
    ent_t e;
    if (mon_en) begin
      chk("alu_ready", alu_ready, rst ? 1'b0 : (mq_alu.size() < 2));
      chk("lsu_ready", lsu_ready, rst ? 1'b0 : (mq_lsu.size() < 2));
      chk("wen", wen, m_wen);
      chk("pend_vec", pend_vec, m_pend());
      if (wen) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL write_unexpected: got waddr=%0d, expected no write", waddr);
        end else begin
          e = exp_q.pop_front();
          chk("waddr", waddr, e.rd);
          chk("wdata", wdata, e.data);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    alu_valid = 1'b0;
    lsu_valid = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  task automatic new_alu(input bit v);
    alu_valid = v;
    alu_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    alu_data  = {$urandom, $urandom};
  endtask

  task automatic new_lsu(input bit v);
    lsu_valid = v;
    lsu_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    lsu_data  = {$urandom, $urandom};
  endtask

  initial begin
    rst = 1'b1; alu_valid = 1'b0; lsu_valid = 1'b0;
    alu_rd = '0; lsu_rd = '0; alu_data = '0; lsu_data = '0;
    cyc(); cyc();
    rst = 1'b0;
    #1;
    chk("rst_wen", wen, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_pend", pend_vec, 0);
    chk("rst_alu_ready", alu_ready, 1);
    chk("rst_lsu_ready", lsu_ready, 1);

    // Single write to x5.
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'hDEAD;
    cyc();
    alu_valid = 1'b0;
    chk("single_pend_c1", pend_vec[5], 1);
    chk("single_wen_c1", wen, 0);
    cyc();
    chk("single_wen_c2", wen, 1);
    chk("single_waddr_c2", waddr, 5);
    chk("single_wdata_c2", wdata, 64'hDEAD);
    chk("single_pend_c2", pend_vec[5], 1);
    cyc();
    chk("single_wen_c3", wen, 0);
    chk("single_pend_c3", pend_vec[5], 0);

    // Ties straight after reset: ALU first, and again on the following tie.
    do_reset();
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 64'h11;
    lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 64'h22;
    cyc();
    alu_valid = 1'b0; lsu_valid = 1'b0;
    cyc();
    chk("tie1_first", waddr, 1);
    cyc();
    chk("tie1_second", waddr, 2);
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 64'h33;
    lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 64'h44;
    cyc();
    alu_valid = 1'b0; lsu_valid = 1'b0;
    cyc();
    chk("tie2_first", waddr, 3);
    cyc();
    chk("tie2_second", waddr, 4);

    // Write to x0 is consumed silently.
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 64'h1234;
    cyc();
    alu_valid = 1'b0;
    chk("x0_wen_c1", wen, 0);
    chk("x0_pend_c1", pend_vec, 0);
    cyc();
    chk("x0_wen_c2", wen, 0);
    chk("x0_pend_c2", pend_vec, 0);
    cyc();
    chk("x0_wen_c3", wen, 0);

    // Both sources saturated: the LSU buffer fills after two acceptances.
    do_reset();
    new_alu(1'b1);
    new_lsu(1'b1);
    alu_rd = 5'd7; lsu_rd = 5'd9;
    cyc();
    chk("bp_lsu_ready_c1", lsu_ready, 1);
    if (m_alu_acc) new_alu(1'b1);
    if (m_lsu_acc) new_lsu(1'b1);
    cyc();
    chk("bp_lsu_ready_c2", lsu_ready, 0);
    for (int i = 0; i < 24; i++) begin
      if (m_alu_acc) new_alu(1'b1);
      if (m_lsu_acc) new_lsu(1'b1);
      cyc();
    end

    // Reset with entries still buffered.
    rst = 1'b1;
    #1;
    chk("midrst_alu_ready_in_rst", alu_ready, 0);
    chk("midrst_lsu_ready_in_rst", lsu_ready, 0);
    cyc();
    rst = 1'b0; alu_valid = 1'b0; lsu_valid = 1'b0;
    #1;
    chk("midrst_wen", wen, 0);
    chk("midrst_pend", pend_vec, 0);
    chk("midrst_alu_ready", alu_ready, 1);
    chk("midrst_lsu_ready", lsu_ready, 1);
    cyc();
    chk("midrst_wen_next", wen, 0);

    // Random traffic; a source holds its request until it is taken.
    for (int i = 0; i < 600; i++) begin
      if (!alu_valid || m_alu_acc) new_alu($urandom_range(0, 3) != 0);
      if (!lsu_valid || m_lsu_acc) new_lsu($urandom_range(0, 3) != 0);
      cyc();
    end
    alu_valid = 1'b0; lsu_valid = 1'b0;
    for (int i = 0; i < 8; i++) cyc();
    chk("drain_outstanding", exp_q.size(), 0);
    chk("drain_wen", wen, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
